// File: rtl/m_fetch_queue.sv
// m_fetch_queue: fetch stage with a program counter, a single-outstanding
// valid/ready request port to a variable-latency instruction memory, and a
// DEPTH-entry FIFO of {pc, instr} pairs that decode pops over valid/ready.
// Branch, jump and panic redirect the PC, flush the FIFO and kill any
// in-flight response.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   branch/_target      redirect to zero-extended branch_target
//   jump/_target        redirect to jump_target
//   panic               redirect to PANIC_PC (highest priority)
//   mem_req_*           fetch request (valid/ready, addr)
//   mem_resp_*          response for the single outstanding request
//   if_valid/pc/instr   FIFO head (pc/instr read as zero when empty)
//   id_ready            decode pops the head when if_valid && id_ready
//   queue_count         occupied FIFO entries
module m_fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        BR_W     = 13,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_1000,
  parameter logic [ADDR_W-1:0]  PANIC_PC = 32'h0000_2000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       branch,
  input  logic [BR_W-1:0]            branch_target,
  input  logic                       jump,
  input  logic [ADDR_W-1:0]          jump_target,
  input  logic                       panic,
  output logic                       mem_req_valid,
  output logic [ADDR_W-1:0]          mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_resp_valid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  output logic                       if_valid,
  output logic [ADDR_W-1:0]          if_pc,
  output logic [DATA_W-1:0]          if_instr,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0]   req_pc, req_pc_nxt;
  logic                kill, kill_nxt;

  logic [ADDR_W-1:0]   q_pc    [DEPTH];
  logic [DATA_W-1:0]   q_instr [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                queue_full;
  logic                req_fire;
  logic                push;
  logic                pop;

  assign redirect    = panic | jump | branch;
  assign redirect_pc = panic ? PANIC_PC :
                       jump  ? jump_target :
                               ADDR_W'(branch_target);

  assign queue_full  = (count == CNT_W'(DEPTH));

  // Gated by reset so no request is presented while reset is held; the first
  // request goes out in the first cycle after release.
  assign mem_req_valid = reset && (state == S_REQ) && !queue_full;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign if_valid    = (count != '0);
  assign if_pc       = if_valid ? q_pc[rd_ptr]    : '0;
  assign if_instr    = if_valid ? q_instr[rd_ptr] : '0;
  assign queue_count = count;

  // A redirect voids any pop in the same cycle.
  assign pop = if_valid && id_ready && !redirect;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    kill_nxt     = kill;
    push         = 1'b0;

    unique case (state)
      S_REQ: begin
        if (req_fire) begin
          fetch_pc_nxt = fetch_pc + ADDR_W'(4);
          req_pc_nxt   = fetch_pc;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          push      = !kill && !redirect;
          kill_nxt  = 1'b0;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    // A response that lands on the redirect edge is consumed (and dropped) right
    // here, so kill is only armed when the stale response is still to come.
    if (redirect) begin
      fetch_pc_nxt = redirect_pc;
      if (((state == S_WAIT) && !mem_resp_valid) || ((state == S_REQ) && req_fire))
        kill_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      kill     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      kill     <= kill_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= req_pc;
      q_instr[wr_ptr] <= mem_resp_data;
    end
  end

endmodule
